// File: rtl/mmu_rcpt.sv
// Range-based fully associative TLB: a lookup hits in one cycle, and a miss waits
// for page-table-walker fills. An entry covers VPNs from its tag to tag+BSIZE.
module mmu_rcpt #(
  parameter int ADDR_WIDTH  = 35,
  parameter int TLB_ENTRIES = 32,
  parameter int VPN_WIDTH   = 23,
  parameter int PPN_WIDTH   = VPN_WIDTH,
  parameter int ATT_WIDTH   = 10,
  parameter int BSIZE_WIDTH = 9,
  parameter int PTE_LOG2    = 1,
  localparam int IDX_W      = $clog2(TLB_ENTRIES),
  localparam int OFF        = ADDR_WIDTH - VPN_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_lookup,
  input  logic [ADDR_WIDTH-1:0] i_virtualAddr,
  output logic                  o_hit,
  output logic                  o_fault,
  output logic [ADDR_WIDTH-1:0] o_physicalAddr,
  output logic                  o_busy,
  input  logic                  i_ptwUpdate,
  input  logic [63:0]           i_ptwPTE,
  input  logic [IDX_W-1:0]      i_indexVictim
);

  localparam int PPN_LO = ATT_WIDTH;
  localparam int BSZ_LO = ATT_WIDTH + PPN_WIDTH;
  localparam int PTE_TOP = ATT_WIDTH + PPN_WIDTH + BSIZE_WIDTH;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                  r_state;
  logic                    r_valid [TLB_ENTRIES];
  logic [VPN_WIDTH-1:0]    r_tag   [TLB_ENTRIES];
  logic [PPN_WIDTH-1:0]    r_ppn   [TLB_ENTRIES];
  logic [BSIZE_WIDTH-1:0]  r_bsize [TLB_ENTRIES];
  logic [ATT_WIDTH-1:0]    r_att   [TLB_ENTRIES];
  logic [VPN_WIDTH-1:0]    r_pend_vpn;
  logic [OFF-1:0]          r_pend_off;

  logic [ATT_WIDTH-1:0]    w_att;
  logic [PPN_WIDTH-1:0]    w_ppn;
  logic [BSIZE_WIDTH-1:0]  w_bsize;
  logic [VPN_WIDTH-1:0]    w_cmp_vpn;
  logic [OFF-1:0]          w_cmp_off;
  logic                    w_match;
  logic [IDX_W-1:0]        w_match_idx;
  logic [VPN_WIDTH-1:0]    w_delta;
  logic [PPN_WIDTH-1:0]    w_pa_ppn;
  logic [ADDR_WIDTH-1:0]   w_pa;
  logic [ATT_WIDTH-1:0]    w_unused_att;
  logic                    w_unused;

  assign w_att   = i_ptwPTE[ATT_WIDTH-1:0];
  assign w_ppn   = i_ptwPTE[BSZ_LO-1:PPN_LO];
  assign w_bsize = i_ptwPTE[PTE_TOP-1:BSZ_LO];

  // A pending miss ignores the live address and keeps comparing the captured one.
  assign w_cmp_vpn = (r_state == S_BUSY) ? r_pend_vpn : i_virtualAddr[ADDR_WIDTH-1:OFF];
  assign w_cmp_off = (r_state == S_BUSY) ? r_pend_off : i_virtualAddr[OFF-1:0];

  // Scan from the top down so that the lowest matching index is the one left standing.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (w_cmp_vpn >= r_tag[i]) &&
          ({1'b0, w_cmp_vpn} <= ({1'b0, r_tag[i]} + (VPN_WIDTH+1)'(r_bsize[i])))) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(i);
      end
    end
  end

  assign w_delta  = w_cmp_vpn - r_tag[w_match_idx];
  assign w_pa_ppn = r_ppn[w_match_idx] + PPN_WIDTH'(w_delta);
  assign w_pa     = ADDR_WIDTH'({w_pa_ppn, w_cmp_off});
  assign o_busy   = (r_state == S_BUSY);

  always_comb begin
    w_unused_att = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) w_unused_att = w_unused_att ^ r_att[i];
  end
  assign w_unused = ^{i_ptwPTE[63:PTE_TOP], w_unused_att, PTE_LOG2[0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      o_hit          <= 1'b0;
      o_fault        <= 1'b0;
      o_physicalAddr <= '0;
      r_pend_vpn     <= '0;
      r_pend_off     <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_ppn[i]   <= '0;
        r_bsize[i] <= '0;
        r_att[i]   <= '0;
      end
    end else begin
      o_fault <= 1'b0;
      o_hit   <= 1'b0;

      // Fill is tagged with whatever VPN the block is currently resolving.
      if (i_ptwUpdate) begin
        r_valid[i_indexVictim] <= w_att[0];
        r_tag[i_indexVictim]   <= w_cmp_vpn;
        r_ppn[i_indexVictim]   <= w_ppn;
        r_bsize[i_indexVictim] <= w_bsize;
        r_att[i_indexVictim]   <= w_att;
      end

      case (r_state)
        S_IDLE: begin
          if (i_lookup) begin
            if (w_match) begin
              o_hit          <= 1'b1;
              o_physicalAddr <= w_pa;
            end else begin
              r_pend_vpn <= i_virtualAddr[ADDR_WIDTH-1:OFF];
              r_pend_off <= i_virtualAddr[OFF-1:0];
              r_state    <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          // An entry that already covers the pending VPN wins over an invalid fill.
          if (w_match) begin
            o_hit          <= 1'b1;
            o_physicalAddr <= w_pa;
            r_state        <= S_IDLE;
          end else if (i_ptwUpdate && !w_att[0]) begin
            o_fault <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_rcpt.sv
// Directed bench for mmu_rcpt: hand-computed translations, fills, a fault,
// overlapping entries and reset during a pending miss.
module tb_mmu_rcpt;

  logic        clk;
  logic        rst_n;
  logic        lookup;
  logic [34:0] va;
  logic        hit;
  logic        fault;
  logic [34:0] pa;
  logic        busy;
  logic        upd;
  logic [63:0] pte;
  logic [4:0]  idx;

  int vectors = 0;
  int errors  = 0;

  mmu_rcpt dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_lookup       (lookup),
    .i_virtualAddr  (va),
    .o_hit          (hit),
    .o_fault        (fault),
    .o_physicalAddr (pa),
    .o_busy         (busy),
    .i_ptwUpdate    (upd),
    .i_ptwPTE       (pte),
    .i_indexVictim  (idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    lookup = 1'b0;
    va     = '0;
    upd    = 1'b0;
    pte    = '0;
    idx    = '0;
    repeat (2) tick();
    chk("rst_hit",   64'(hit),   64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_busy",  64'(busy),  64'd0);
    chk("rst_pa",    64'(pa),    64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_hit",  64'(hit),  64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // Miss on empty TLB
    lookup = 1'b1; va = 35'h1234;
    tick();
    chk("miss_busy", 64'(busy), 64'd1);
    chk("miss_hit",  64'(hit),  64'd0);

    // Fill index 0: PPN 0x10C840, BSIZE 2, tag = pending VPN 1
    upd = 1'b1; pte = 64'h0000_0004_4321_03FF; idx = 5'd0;
    tick();
    chk("fill_wait_busy", 64'(busy), 64'd1);
    chk("fill_wait_hit",  64'(hit),  64'd0);
    upd = 1'b0;
    tick();
    chk("fill_hit",  64'(hit),  64'd1);
    chk("fill_pa",   64'(pa),   64'h10C840234);
    chk("fill_busy", 64'(busy), 64'd0);
    tick();
    chk("hold_hit", 64'(hit), 64'd1);
    chk("hold_pa",  64'(pa),  64'h10C840234);

    // Top of the range (VPN 3 = tag + BSIZE)
    va = 35'h3ABC;
    tick();
    chk("range_hit", 64'(hit), 64'd1);
    chk("range_pa",  64'(pa),  64'h10C842ABC);

    // One past the range
    va = 35'h4ABC;
    tick();
    chk("past_busy",   64'(busy), 64'd1);
    chk("past_hit",    64'(hit),  64'd0);
    chk("past_pa_hold", 64'(pa),  64'h10C842ABC);

    // Live address is ignored while busy
    va = 35'h1234;
    tick();
    chk("ign_busy", 64'(busy), 64'd1);
    chk("ign_hit",  64'(hit),  64'd0);

    // Invalid fill resolves the miss as a fault
    upd = 1'b1; pte = 64'h0000_0004_4321_03FE; idx = 5'd5;
    tick();
    chk("fault_pulse", 64'(fault), 64'd1);
    chk("fault_busy",  64'(busy),  64'd0);
    chk("fault_hit",   64'(hit),   64'd0);
    upd = 1'b0; lookup = 1'b0;
    tick();
    chk("fault_end", 64'(fault), 64'd0);
    chk("fault_pa",  64'(pa),    64'h10C842ABC);

    // The invalid entry must not match VPN 4
    lookup = 1'b1; va = 35'h4ABC;
    tick();
    chk("inv_busy", 64'(busy), 64'd1);
    upd = 1'b1; pte = 64'h0000_0000_0008_0001; idx = 5'd1;
    tick();
    chk("f1_wait", 64'(hit), 64'd0);
    upd = 1'b0;
    tick();
    chk("f1_hit", 64'(hit), 64'd1);
    chk("f1_pa",  64'(pa),  64'h200ABC);

    // Overlap: index 0 also covers VPN 4, written from IDLE
    lookup = 1'b0; va = 35'h4000;
    upd = 1'b1; pte = 64'h0000_0000_000C_0001; idx = 5'd0;
    tick();
    chk("ovl_wr_hit", 64'(hit), 64'd0);
    upd = 1'b0; lookup = 1'b1; va = 35'h4ABC;
    tick();
    chk("ovl_hit", 64'(hit), 64'd1);
    chk("ovl_pa",  64'(pa),  64'h300ABC);

    // Update together with lookup: write only visible from the next cycle
    va = 35'h9123; upd = 1'b1; pte = 64'h0000_0000_0001_4001; idx = 5'd3;
    tick();
    chk("same_busy", 64'(busy), 64'd1);
    chk("same_hit",  64'(hit),  64'd0);
    upd = 1'b0;
    tick();
    chk("same_hit2", 64'(hit), 64'd1);
    chk("same_pa",   64'(pa),  64'h50123);

    // Reset in the middle of a pending miss
    va = 35'h7000;
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hit",  64'(hit),  64'd0);
    chk("mid_rst_pa",   64'(pa),   64'd0);
    rst_n = 1'b1; va = 35'h4ABC;
    tick();
    chk("post_rst_empty", 64'(busy), 64'd1);
    chk("post_rst_hit",   64'(hit),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mmu_rcpt.md
MMU_RCPT -- requirements
Module: mmu_rcpt

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 35, virtual/physical address width.
REQ-002 SHALL have parameter TLB_ENTRIES, default 32, number of fully associative TLB entries.
REQ-003 SHALL have parameter VPN_WIDTH, default 23, virtual page number width; page offset width OFF = ADDR_WIDTH-VPN_WIDTH (12).
REQ-004 SHALL have parameter PPN_WIDTH, default VPN_WIDTH, physical page number width.
REQ-005 SHALL have parameter ATT_WIDTH, default 10, PTE attribute field width; ATT[0] is the valid bit.
REQ-006 SHALL have parameter BSIZE_WIDTH, default 9, range (block) size field width.
REQ-007 SHALL have parameter PTE_LOG2, default 1, log2 of PTE size in 64-bit words; carried for integration only, with no functional effect.
REQ-008 SHALL use one clock and an asynchronous, active-low reset: i_clk  in  1  clock, rising edge; i_rst_n  in  1  asynchronous active-low reset.
REQ-009 i_lookup  in  1  level request to translate i_virtualAddr.
REQ-010 i_virtualAddr  in  ADDR_WIDTH  virtual address; VPN = [ADDR_WIDTH-1:OFF], offset = [OFF-1:0].
REQ-011 o_hit  out  1  translation valid this cycle.
REQ-012 o_fault  out  1  one-cycle pulse: pending miss resolved by an invalid PTE.
REQ-013 o_physicalAddr  out  ADDR_WIDTH  translated address.
REQ-014 o_busy  out  1  miss pending, waiting for page-table-walker fill.
REQ-015 i_ptwUpdate  in  1  walker write strobe, one entry per cycle.
REQ-016 i_ptwPTE  in  64  PTE: [ATT_WIDTH-1:0]=ATT, [ATT_WIDTH+PPN_WIDTH-1:ATT_WIDTH]=PPN (bits 32:10), next BSIZE_WIDTH bits=BSIZE (bits 41:33), upper bits ignored.
REQ-017 i_indexVictim  in  log2(TLB_ENTRIES)  entry index written on update.

Function
REQ-018 Each entry SHALL hold valid, base VPN tag, PPN, BSIZE, ATT.
REQ-019 An entry SHALL match VPN v when valid and tag <= v <= tag+BSIZE (unsigned, tag+BSIZE computed at VPN_WIDTH+1 bits, so there is no wrap).
REQ-020 On multiple matches, the lowest index SHALL win.
REQ-021 Translated PA SHALL be {PPN + (v - tag), offset}, truncated to ADDR_WIDTH.
REQ-022 States: IDLE, BUSY. o_busy = (state==BUSY).
REQ-023 IDLE, i_lookup=1, match: at the next edge o_hit=1 and o_physicalAddr=PA; o_hit stays 1 each cycle while i_lookup=1 and it matches.
REQ-024 IDLE, i_lookup=1, miss: at the next edge capture pending VPN/offset, go BUSY, o_hit=0.
REQ-025 IDLE, i_lookup=0: o_hit=0 at the next edge; o_physicalAddr holds its last value.
REQ-026 In BUSY, i_lookup and i_virtualAddr SHALL be ignored; the pending address is held.
REQ-027 Update (any state): at the edge with i_ptwUpdate=1, entry[i_indexVictim] <= {valid=ATT[0], tag=pending VPN (in IDLE: current i_virtualAddr VPN), PPN, BSIZE, ATT}.
REQ-028 In BUSY, each cycle the pending VPN SHALL be compared against the stored array.
REQ-029 On match, at the next edge: o_hit=1, o_physicalAddr=PA, state to IDLE. Update-to-hit latency is 2 edges.
REQ-030 If an update in BUSY writes ATT[0]=0, the next edge SHALL give o_fault=1 for one cycle, o_hit=0, state IDLE; that entry is invalid.
REQ-031 Update with i_lookup in the same cycle SHALL be allowed; the write is visible to lookups from the next cycle.
REQ-032 Writes to the same index SHALL be last-writer-wins; no other replacement logic exists.

Reset
REQ-033 While i_rst_n=0: all entries invalid, state IDLE, o_hit=0, o_fault=0, o_busy=0, o_physicalAddr=0.
REQ-034 Reset asserted mid-BUSY SHALL abandon the pending miss immediately.

Verification
REQ-035 Reset, then idle -> all outputs 0, o_busy=0.
REQ-036 Lookup VA 0x1234 on empty TLB -> next cycle o_busy=1, o_hit=0.
REQ-037 Fill test:
- Step 1: keep the lookup of REQ-036 high.
- Step 2: write index 0 with PTE 0x0000_0004_4321_03FF (PPN 0x10C840, BSIZE 2).
- Required response: o_hit=1 with PA 0x10C840234, and o_busy=0.
REQ-038 After REQ-037: lookup 0x3ABC -> hit, PA 0x10C842ABC. Lookup 0x4ABC -> miss, o_busy=1.
REQ-039 While BUSY, write PTE with ATT[0]=0 -> one-cycle o_fault=1, o_busy=0, o_hit=0.
REQ-040 Overlapping entries at indices 1 and 0 both covering VA -> index 0 PA returned. Reset asserted during BUSY -> o_busy=0 and the TLB is empty.
